// File: rtl/median_line_buffer_if.sv
// Pixel-in / column-out bundle of the median line buffer.
// The design takes the slave view; the upstream source and the window buffer take the master view.
interface median_line_buffer_if #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 640
);
  localparam int CW = $clog2(IMG_W);

  logic             in_valid;
  logic             in_sof;
  logic [WIDTH-1:0] in_data;
  logic             col_valid;
  logic [WIDTH-1:0] col0, col1, col2, col3, col4, col5, col6, col7, col8, col9, col10;
  logic [CW-1:0]    col_x;
  logic             col_eol;
  logic             fill_done;

  modport slave (
    input  in_valid, in_sof, in_data,
    output col_valid, col0, col1, col2, col3, col4, col5, col6, col7, col8, col9, col10,
    output col_x, col_eol, fill_done
  );

  modport master (
    output in_valid, in_sof, in_data,
    input  col_valid, col0, col1, col2, col3, col4, col5, col6, col7, col8, col9, col10,
    input  col_x, col_eol, fill_done
  );
endinterface

// File: rtl/median_line_buffer.sv
// Raster-to-column converter: ten shifting line memories turn a raster pixel stream
// into 11-pixel vertical columns (oldest row first) for the 11x11 median window.
module median_line_buffer #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 640
) (
  input logic                clk,
  input logic                rst,
  median_line_buffer_if.slave bus
);
  localparam int              CW        = $clog2(IMG_W);
  localparam int              LINES     = 10;
  localparam logic [3:0]      FULL_ROWS = 4'd10;
  localparam logic [CW-1:0]   LAST_X    = CW'(IMG_W - 1);

  logic [CW-1:0]    wx_reg, wx_next, addr;
  logic [3:0]       rows_reg, rows_next;
  logic             emit;
  logic [WIDTH-1:0] rd_data [LINES];
  logic [WIDTH-1:0] wr_data [LINES];
  logic [WIDTH-1:0] col_reg [LINES+1];
  logic [CW-1:0]    col_x_reg;
  logic             col_valid_reg, col_eol_reg, fill_done_reg;

  // A start-of-frame pixel always lands at column 0, wherever the counter was.
  assign addr = bus.in_sof ? '0 : wx_reg;
  assign emit = bus.in_valid && !bus.in_sof && (rows_reg == FULL_ROWS);

  // Each line memory reads asynchronously so the old word can be shifted one line
  // down in the same cycle it is read (read-before-write on one address).
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
      logic [WIDTH-1:0] mem [IMG_W];

      if (gi == 0) begin : g_head
        assign wr_data[gi] = bus.in_data;
      end else begin : g_shift
        assign wr_data[gi] = rd_data[gi-1];
      end

      assign rd_data[gi] = mem[addr];

      always_ff @(posedge clk) begin
        if (bus.in_valid) begin
          mem[addr] <= wr_data[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    wx_next   = wx_reg;
    rows_next = rows_reg;
    if (bus.in_valid) begin
      if (bus.in_sof) begin
        wx_next   = CW'(1);
        rows_next = '0;
      end else if (wx_reg == LAST_X) begin
        wx_next = '0;
        if (rows_reg != FULL_ROWS) begin
          rows_next = rows_reg + 4'd1;
        end
      end else begin
        wx_next = wx_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wx_reg        <= '0;
      rows_reg      <= '0;
      fill_done_reg <= 1'b0;
      col_valid_reg <= 1'b0;
      col_eol_reg   <= 1'b0;
      col_x_reg     <= '0;
      for (int k = 0; k <= LINES; k++) begin
        col_reg[k] <= '0;
      end
    end else begin
      wx_reg        <= wx_next;
      rows_reg      <= rows_next;
      fill_done_reg <= (rows_next == FULL_ROWS);
      col_valid_reg <= emit;
      // Column data only moves on accepted pixels so it holds through input gaps.
      if (bus.in_valid) begin
        col_x_reg      <= addr;
        col_eol_reg    <= emit && (wx_reg == LAST_X);
        col_reg[LINES] <= bus.in_data;
        for (int k = 0; k < LINES; k++) begin
          col_reg[LINES-1-k] <= rd_data[k];
        end
      end
    end
  end

  assign bus.col_valid = col_valid_reg;
  assign bus.col_x     = col_x_reg;
  assign bus.col_eol   = col_eol_reg;
  assign bus.fill_done = fill_done_reg;
  assign bus.col0      = col_reg[0];
  assign bus.col1      = col_reg[1];
  assign bus.col2      = col_reg[2];
  assign bus.col3      = col_reg[3];
  assign bus.col4      = col_reg[4];
  assign bus.col5      = col_reg[5];
  assign bus.col6      = col_reg[6];
  assign bus.col7      = col_reg[7];
  assign bus.col8      = col_reg[8];
  assign bus.col9      = col_reg[9];
  assign bus.col10     = col_reg[10];
endmodule

// File: tb/tb_median_line_buffer.sv
// Scoreboard bench for median_line_buffer: IMG_W=8, pixel value (16*y + x) mod 512.
module tb_median_line_buffer;
  localparam int WIDTH = 9;
  localparam int IMG_W = 8;

  typedef struct {
    int               acc;
    logic [2:0]       x;
    logic             eol;
    logic [10:0][8:0] col;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   applied = 0;
  int   miscompares = 0;
  int   fx = 0;
  int   fy = 0;
  exp_t q[$];
  logic [10:0][8:0] act;

  median_line_buffer_if #(.WIDTH(WIDTH), .IMG_W(IMG_W)) bus ();

  median_line_buffer #(.WIDTH(WIDTH), .IMG_W(IMG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign act = {bus.col10, bus.col9, bus.col8, bus.col7, bus.col6, bus.col5,
                bus.col4, bus.col3, bus.col2, bus.col1, bus.col0};

  function automatic logic [8:0] pix(input int y, input int x);
    return 9'((16 * y + x) % 512);
  endfunction

  // Drives one cycle of input; accepted pixels that should emit are queued.
  task automatic send(input logic v, input logic sof);
    exp_t e;
    bus.in_valid = v;
    bus.in_sof   = sof;
    if (v) begin
      if (sof) begin
        fx = 0;
        fy = 0;
      end
      bus.in_data = pix(fy, fx);
      if (fy >= 10 && !sof) begin
        e.acc = cyc;
        e.x   = 3'(fx);
        e.eol = (fx == IMG_W - 1);
        for (int k = 0; k < 11; k++) e.col[k] = pix(fy - 10 + k, fx);
        q.push_back(e);
      end
      fx++;
      if (fx == IMG_W) begin
        fx = 0;
        fy++;
      end
    end else begin
      bus.in_data = 9'($urandom_range(0, 511));
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every col_valid pulse must match the oldest queued column, one cycle late.
  always @(negedge clk) begin
    if (rst) begin
      while (q.size() > 0 && q[0].acc + 1 < cyc) begin
        applied++;
        miscompares++;
        $display("FAIL missed_col: no col_valid for x=%0d, required at cycle %0d (now %0d)",
                 q[0].x, q[0].acc + 1, cyc);
        void'(q.pop_front());
      end
      if (bus.col_valid) begin
        exp_t e;
        applied++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_col: col_valid=1 col_x=%0d, required col_valid=0", bus.col_x);
        end else begin
          e = q.pop_front();
          if (cyc !== e.acc + 1) begin
            miscompares++;
            $display("FAIL col_latency: cycle %0d, required %0d", cyc, e.acc + 1);
          end
          applied++;
          if ({bus.col_x, bus.col_eol} !== {e.x, e.eol}) begin
            miscompares++;
            $display("FAIL col_pos: x=%0d eol=%0b, required x=%0d eol=%0b",
                     bus.col_x, bus.col_eol, e.x, e.eol);
          end
          applied++;
          if (act !== e.col) begin
            miscompares++;
            $display("FAIL col_data: got %h, required %h (x=%0d)", act, e.col, e.x);
          end
        end
      end
    end
  end

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    applied++;
    if ({bus.col_valid, bus.col_eol, bus.fill_done, bus.col_x, act} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: v=%0b eol=%0b fd=%0b x=%0d cols=%h, required all 0",
               bus.col_valid, bus.col_eol, bus.fill_done, bus.col_x, act);
    end
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      applied++;
      if ({bus.col_valid, bus.col_eol, bus.fill_done, bus.col_x, act} !== '0) begin
        miscompares++;
        $display("FAIL idle_after_reset: v=%0b fd=%0b cols=%h, required all 0",
                 bus.col_valid, bus.fill_done, act);
      end
    end
  endtask

  task automatic test_fill();
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        send(1'b1, (y == 0 && x == 0));
        applied++;
        if (bus.col_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_no_col: col_valid=%0b at (%0d,%0d), required 0", bus.col_valid, y, x);
        end
        applied++;
        if (bus.fill_done !== (y == 9 && x == IMG_W - 1)) begin
          miscompares++;
          $display("FAIL fill_done: %0b after (%0d,%0d), required %0b",
                   bus.fill_done, y, x, (y == 9 && x == IMG_W - 1));
        end
      end
    end
  endtask

  task automatic test_column_data();
    for (int x = 0; x < IMG_W; x++) begin
      send(1'b1, 1'b0);
      if (x == 0) begin
        applied++;
        if ({bus.col_valid, bus.col_x, bus.col0, bus.col5, bus.col10} !== {1'b1, 3'd0, 9'd0, 9'd80, 9'd160}) begin
          miscompares++;
          $display("FAIL first_col: v=%0b x=%0d col0=%0d col5=%0d col10=%0d, required 1 0 0 80 160",
                   bus.col_valid, bus.col_x, bus.col0, bus.col5, bus.col10);
        end
      end
      if (x == 3) begin
        applied++;
        if ({bus.col0, bus.col10} !== {9'd3, 9'd163}) begin
          miscompares++;
          $display("FAIL col_x3: col0=%0d col10=%0d, required 3 163", bus.col0, bus.col10);
        end
      end
      applied++;
      if ({bus.col_valid, bus.col_eol} !== {1'b1, (x == IMG_W - 1)}) begin
        miscompares++;
        $display("FAIL col_eol: v=%0b eol=%0b at x=%0d, required 1 %0b",
                 bus.col_valid, bus.col_eol, x, (x == IMG_W - 1));
      end
    end
  endtask

  task automatic test_stalls();
    for (int n = 0; n < IMG_W; n++) begin
      send(1'b1, 1'b0);
      if (n == 0) begin
        applied++;
        if ({bus.col0, bus.col10} !== {9'd16, 9'd176}) begin
          miscompares++;
          $display("FAIL stall_x0: col0=%0d col10=%0d, required 16 176", bus.col0, bus.col10);
        end
      end
      if (n < IMG_W - 1) begin
        repeat (2) begin
          send(1'b0, 1'b0);
          applied++;
          if ({bus.col_valid, bus.col_x, bus.col0} !== {1'b0, 3'(n), pix(1, n)}) begin
            miscompares++;
            $display("FAIL stall_hold: v=%0b x=%0d col0=%0d, required 0 %0d %0d",
                     bus.col_valid, bus.col_x, bus.col0, n, pix(1, n));
          end
        end
      end
    end
  endtask

  task automatic test_sof_midframe();
    for (int x = 0; x < 4; x++) send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    applied++;
    if ({bus.col_valid, bus.fill_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL sof_pixel: v=%0b fd=%0b, required 0 0", bus.col_valid, bus.fill_done);
    end
    for (int i = 1; i < 10 * IMG_W; i++) begin
      send(1'b1, 1'b0);
      applied++;
      if (bus.col_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL sof_refill: col_valid=1 at new-frame pixel %0d, required 0", i);
      end
    end
    send(1'b1, 1'b0);
    applied++;
    if ({bus.col_valid, bus.col_x, bus.col0, bus.col10, bus.fill_done} !== {1'b1, 3'd0, 9'd0, 9'd160, 1'b1}) begin
      miscompares++;
      $display("FAIL sof_first_col: v=%0b x=%0d col0=%0d col10=%0d fd=%0b, required 1 0 0 160 1",
               bus.col_valid, bus.col_x, bus.col0, bus.col10, bus.fill_done);
    end
    for (int i = 1; i < IMG_W + 5; i++) send(1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    applied++;
    if ({bus.col_valid, bus.col_eol, bus.fill_done, bus.col_x, act} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: v=%0b fd=%0b x=%0d cols=%h, required all 0",
               bus.col_valid, bus.fill_done, bus.col_x, act);
    end
    rst = 1'b1;
    q.delete();
    fx = 0;
    fy = 0;
    for (int i = 0; i < 10 * IMG_W; i++) begin
      send(1'b1, 1'b0);
      applied++;
      if (bus.col_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_fill: col_valid=1 at pixel %0d, required 0", i);
      end
    end
    send(1'b1, 1'b0);
    applied++;
    if ({bus.col_valid, bus.col_x, bus.col0, bus.col10} !== {1'b1, 3'd0, 9'd0, 9'd160}) begin
      miscompares++;
      $display("FAIL post_reset_81st: v=%0b x=%0d col0=%0d col10=%0d, required 1 0 0 160",
               bus.col_valid, bus.col_x, bus.col0, bus.col10);
    end
    repeat (3) send(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_column_data();
    test_stalls();
    test_sof_midframe();
    test_async_reset();
    applied++;
    if (q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d columns outstanding, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/median_line_buffer.md
# median_line_buffer

Raster-to-column converter that feeds the 11x11 median window buffer. It accepts one pixel per cycle in raster order and stores the previous 10 image lines in on-chip line memories. For every accepted pixel it emits the 11 vertically aligned pixels at that column, oldest row first. It sits directly upstream of the window buffer: `col_valid` drives its `clken`, and `col0..col10` drive its `pixel0..pixel10`.

## Interface

- `WIDTH`, 9: pixel bit width.
- `IMG_W`, 640: pixels per image line (≥ 2). Column counter width is `CW = $clog2(IMG_W)`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input pixel qualifier; one pixel is accepted per cycle while high.
- `in_sof`  in  1  start of frame; meaningful only when `in_valid` is high.
- `in_data`  in  WIDTH  input pixel.
- `col_valid`  out  1  output column qualifier; high for exactly one cycle per emitted column.
- `col0` .. `col10`  out  WIDTH each  column pixels. `col0` is 10 rows above the current pixel; `col10` is the current pixel.
- `col_x`  out  CW  column index of the emitted column.
- `col_eol`  out  1  high together with `col_valid` when `col_x == IMG_W-1`.
- `fill_done`  out  1  level; high once 10 full lines of the current frame are stored.

## Operation

- Storage: 10 line memories L0..L9, each `IMG_W` x `WIDTH`, all addressed by the write column counter `wx`.
- Per accepted pixel, at address `wx`:
  - read all memories first;
  - write `in_data` into L0;
  - write the old L(k) value into L(k+1), for k = 0..8.
  - This is read-before-write on the same address.
- Column mapping of the read data:
  - `col10` = `in_data`
  - `col9` = old L0
  - …
  - `col0` = old L9
- Counters:
  - `wx` counts 0..`IMG_W`-1, wraps to 0, and advances only on accepted pixels.
  - `rows` (4 bits) is the number of completed lines. It increments when an accepted pixel has `wx == IMG_W-1` and saturates at 10.
- Emission rule: an accepted pixel produces `col_valid = 1` on the next cycle only if `rows == 10` at acceptance. Earlier pixels update the memories but emit nothing.
- `fill_done` equals `(rows == 10)`, registered.
- `in_valid = 1` with `in_sof = 1`:
  - the pixel is treated as x = 0 of row 0;
  - `wx` becomes 1 after the pixel, `rows` becomes 0;
  - the pixel is written into L0;
  - no column is emitted;
  - this applies at any position, including mid-line. Stale memory content is masked by `rows`.
- `in_sof` with `in_valid = 0` is ignored.
- `in_valid = 0`: no counter or memory changes; `col0..col10`, `col_x` and `col_eol` hold; `col_valid = 0`.
- Memory content is not reset. Correctness relies only on the `rows` gating.

## Timing

- Latency: 1 cycle from pixel acceptance to the registered outputs.
- Throughput: 1 pixel per cycle sustained, with no backpressure.
- Reset values:
  - `col_valid` = 0, `col_eol` = 0, `fill_done` = 0;
  - `col0..col10` = 0, `col_x` = 0;
  - `wx` = 0, `rows` = 0.
- Reset asserted mid-frame clears the counters immediately. Output resumes only after 10 new full lines.
- After reset, lines are counted from the first accepted pixel even without `in_sof`.
- First emitted column of a frame: the pixel at row 10, x = 0. Its `col_valid` is high in the cycle after that pixel is accepted.
- `col_valid` gaps mirror `in_valid` gaps exactly, delayed by 1 cycle.
- Wrap: `col_eol` is high for the x = `IMG_W`-1 column; the next emitted column has `col_x` = 0.

## Test plan

Bench parameters: `IMG_W` = 8, `WIDTH` = 9, stimulus pixel value = (16·y + x) mod 512, `in_sof` on pixel (0,0).

- **Reset:** hold `rst` = 0 for 3 cycles, then release with `in_valid` = 0 → all outputs 0, `col_valid` never asserts.
- **Fill:** stream rows 0..9 continuously → `col_valid` stays 0 throughout; `fill_done` rises the cycle after pixel (9,7) is accepted.
- **Column data:** continue with row 10 → the first `col_valid` has `col_x` = 0, `col0` = 0, `col5` = 80, `col10` = 160. At x = 3: `col0` = 3, `col10` = 163. At x = 7: `col_eol` = 1.
- **Stalls:** row 11 with `in_valid` toggling 1,0,0,1,… → 8 `col_valid` pulses, each 1 cycle after its accepted pixel; outputs hold during gaps; x = 0 gives `col0` = 16, `col10` = 176.
- **Mid-frame sof:** assert `in_sof` at row 12, x = 4 → no further `col_valid` until 10 new lines complete. The first new column has `col_x` = 0 and data from the new frame only.
- **Async reset mid-line:** pulse `rst` low for less than 1 cycle at row 11, x = 5 → outputs are 0 immediately; the following 80 pixels emit nothing; the 81st pixel (with counting restarted at the first pixel after reset) emits.
